// File: rtl/cdbus_mm_master.sv
// Avalon-MM initiator for the cdbus controller csr/rx_mm/tx_mm ports.
// Runs one command at a time: a single-beat read or write, then exactly one response.
module cdbus_mm_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_target,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [3:0]  cmd_byteenable,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  output logic        csr_write,
  output logic [3:0]  csr_byteenable,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata,
  output logic [5:0]  rx_mm_address,
  output logic        rx_mm_read,
  output logic        rx_mm_write,
  output logic [3:0]  rx_mm_byteenable,
  output logic [31:0] rx_mm_writedata,
  input  logic [31:0] rx_mm_readdata,
  output logic [5:0]  tx_mm_address,
  output logic        tx_mm_read,
  output logic        tx_mm_write,
  output logic [3:0]  tx_mm_byteenable,
  output logic [31:0] tx_mm_writedata,
  input  logic [31:0] tx_mm_readdata,
  input  logic        irq,
  output logic        irq_sync,
  output logic        irq_rise
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  tgt_q, tgt_d;
  logic        wr_q, wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        irq_meta_q, irq_sync_q, irq_sync_dly_q;
  logic        illegal;

  assign illegal = (cmd_target == 2'd3) || ((cmd_target == 2'd0) && (cmd_addr[5:4] != 2'b00));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    csr_read    = 1'b0;
    csr_write   = 1'b0;
    rx_mm_read  = 1'b0;
    rx_mm_write = 1'b0;
    tx_mm_read  = 1'b0;
    tx_mm_write = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          tgt_d   = cmd_target;
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          be_d    = cmd_byteenable;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          err_d   = illegal;
          state_d = illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        csr_read    = (tgt_q == 2'd0) && !wr_q;
        csr_write   = (tgt_q == 2'd0) &&  wr_q;
        rx_mm_read  = (tgt_q == 2'd1) && !wr_q;
        rx_mm_write = (tgt_q == 2'd1) &&  wr_q;
        tx_mm_read  = (tgt_q == 2'd2) && !wr_q;
        tx_mm_write = (tgt_q == 2'd2) &&  wr_q;
        if (wr_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter hits zero in cycle T+READ_LATENCY, when slave readdata is valid.
        if (cnt_q == 3'd0) begin
          unique case (tgt_q)
            2'd0:    rdata_d = csr_readdata;
            2'd1:    rdata_d = rx_mm_readdata;
            default: rdata_d = tx_mm_readdata;
          endcase
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready keeps it low during reset and for the first cycle after.
    cmd_ready_d = (state_d == S_IDLE);
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = (state_q == S_RESP);
  assign rsp_data         = rdata_q;
  assign rsp_write        = wr_q;
  assign rsp_err          = err_q;

  assign csr_address      = addr_q[3:0];
  assign csr_byteenable   = be_q;
  assign csr_writedata    = wdata_q;
  assign rx_mm_address    = addr_q;
  assign rx_mm_byteenable = be_q;
  assign rx_mm_writedata  = wdata_q;
  assign tx_mm_address    = addr_q;
  assign tx_mm_byteenable = be_q;
  assign tx_mm_writedata  = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_meta_q     <= 1'b0;
      irq_sync_q     <= 1'b0;
      irq_sync_dly_q <= 1'b0;
    end else begin
      irq_meta_q     <= irq;
      irq_sync_q     <= irq_meta_q;
      irq_sync_dly_q <= irq_sync_q;
    end
  end

  assign irq_sync = irq_sync_q;
  assign irq_rise = irq_sync_q & ~irq_sync_dly_q;

endmodule

// File: tb/tb_cdbus_mm_master.sv
// Directed bench for cdbus_mm_master with READ_LATENCY=2 and fixed-latency slave models.
module tb_cdbus_mm_master;

  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_target = '0;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [3:0]  cmd_byteenable = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_write, rsp_err;
  logic [3:0]  csr_address;
  logic        csr_read, csr_write;
  logic [3:0]  csr_byteenable;
  logic [31:0] csr_writedata, csr_readdata;
  logic [5:0]  rx_mm_address;
  logic        rx_mm_read, rx_mm_write;
  logic [3:0]  rx_mm_byteenable;
  logic [31:0] rx_mm_writedata, rx_mm_readdata;
  logic [5:0]  tx_mm_address;
  logic        tx_mm_read, tx_mm_write;
  logic [3:0]  tx_mm_byteenable;
  logic [31:0] tx_mm_writedata, tx_mm_readdata;
  logic        irq = 1'b0;
  logic        irq_sync, irq_rise;

  always #5 clk = ~clk;

  cdbus_mm_master #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_byteenable(cmd_byteenable),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_byteenable(csr_byteenable), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata),
    .rx_mm_address(rx_mm_address), .rx_mm_read(rx_mm_read), .rx_mm_write(rx_mm_write),
    .rx_mm_byteenable(rx_mm_byteenable), .rx_mm_writedata(rx_mm_writedata),
    .rx_mm_readdata(rx_mm_readdata),
    .tx_mm_address(tx_mm_address), .tx_mm_read(tx_mm_read), .tx_mm_write(tx_mm_write),
    .tx_mm_byteenable(tx_mm_byteenable), .tx_mm_writedata(tx_mm_writedata),
    .tx_mm_readdata(tx_mm_readdata),
    .irq(irq), .irq_sync(irq_sync), .irq_rise(irq_rise)
  );

  // Slaves present data only in cycle T+2; any other cycle shows a poison word.
  logic [1:0] csr_pipe = '0, rx_pipe = '0, tx_pipe = '0;
  always @(posedge clk) begin
    csr_pipe <= {csr_pipe[0], csr_read};
    rx_pipe  <= {rx_pipe[0], rx_mm_read};
    tx_pipe  <= {tx_pipe[0], tx_mm_read};
  end
  assign csr_readdata   = csr_pipe[1] ? 32'h0000_C5C5 : 32'hBAD0_0001;
  assign rx_mm_readdata = rx_pipe[1]  ? 32'hDEAD_BEEF : 32'hBAD0_0002;
  assign tx_mm_readdata = tx_pipe[1]  ? 32'hA1B2_C3D4 : 32'hBAD0_0003;

  logic [5:0] stb;
  assign stb = {tx_mm_write, tx_mm_read, rx_mm_write, rx_mm_read, csr_write, csr_read};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [5:0]  r_stb, r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd, r_data;
  logic        r_wr, r_err, r_ovl;
  int          r_nstb, r_stb_cyc, r_rsp_cyc;

  task automatic wait_ready();
    int w;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command with rsp_ready high; record strobe and response timing relative to launch.
  task automatic do_cmd(input logic [1:0] tgt, input logic wr, input logic [5:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    r_stb = '0; r_nstb = 0; r_stb_cyc = -1; r_rsp_cyc = -1; r_ovl = 1'b0;
    r_addr = '0; r_be = '0; r_wd = '0; r_data = '0; r_wr = 1'b0; r_err = 1'b0;
    wait_ready();
    cmd_valid = 1'b1; cmd_target = tgt; cmd_write = wr; cmd_addr = addr;
    cmd_byteenable = be; cmd_wdata = wd; rsp_ready = 1'b1;
    for (int c = 1; c <= 30 && r_rsp_cyc < 0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (stb != 6'b0) begin
        r_nstb++;
        r_stb |= stb;
        if ($countones(stb) > 1) r_ovl = 1'b1;
        if (r_stb_cyc < 0) begin
          r_stb_cyc = c;
          case (tgt)
            2'd0:    begin r_addr = {2'b00, csr_address}; r_be = csr_byteenable;   r_wd = csr_writedata;   end
            2'd1:    begin r_addr = rx_mm_address;        r_be = rx_mm_byteenable; r_wd = rx_mm_writedata; end
            default: begin r_addr = tx_mm_address;        r_be = tx_mm_byteenable; r_wd = tx_mm_writedata; end
          endcase
        end
      end
      if (rsp_valid) begin
        r_rsp_cyc = c; r_data = rsp_data; r_wr = rsp_write; r_err = rsp_err;
      end
    end
    if (r_rsp_cyc < 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_cmd(input string tag, input logic [5:0] e_stb, input int e_stb_cyc,
                            input int e_rsp_cyc, input logic [31:0] e_data, input logic e_wr,
                            input logic e_err);
    chk({tag, "_stb"},     32'(r_stb), 32'(e_stb));
    chk({tag, "_nstb"},    32'(r_nstb), (e_stb != 6'b0) ? 32'd1 : 32'd0);
    chk({tag, "_overlap"}, 32'(r_ovl), 32'd0);
    chk({tag, "_stb_cyc"}, 32'(r_stb_cyc), 32'(e_stb_cyc));
    chk({tag, "_rsp_cyc"}, 32'(r_rsp_cyc), 32'(e_rsp_cyc));
    chk({tag, "_data"},    r_data, e_data);
    chk({tag, "_write"},   32'(r_wr), 32'(e_wr));
    chk({tag, "_err"},     32'(r_err), 32'(e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_cnt, rise_cyc, w;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stb",       32'(stb), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_irq_rise",  32'(irq_rise), 32'd0);
    chk("rst_addr",      32'(rx_mm_address), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_stb",       32'(stb), 32'd0);
    chk("post_rst_irq_rise",  32'(irq_rise), 32'd0);

    // Writes take ISSUE then RESP; reads respond RL+1 cycles after the strobe
    do_cmd(2'd0, 1'b1, 6'd3, 4'hF, 32'h0000_00A5);
    expect_cmd("wr_csr", 6'b000010, 1, 2, 32'd0, 1'b1, 1'b0);
    chk("wr_csr_addr", 32'(r_addr), 32'd3);
    chk("wr_csr_wd",   r_wd, 32'h0000_00A5);
    chk("wr_csr_be",   32'(r_be), 32'hF);
    @(negedge clk);
    chk("addr_hold",   32'(csr_address), 32'd3);

    do_cmd(2'd1, 1'b0, 6'h3F, 4'hF, 32'd0);
    expect_cmd("rd_rx", 6'b000100, 1, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rd_rx_addr", 32'(r_addr), 32'h3F);

    do_cmd(2'd2, 1'b1, 6'h2A, 4'h5, 32'h1234_5678);
    expect_cmd("wr_tx", 6'b100000, 1, 2, 32'd0, 1'b1, 1'b0);
    chk("wr_tx_addr", 32'(r_addr), 32'h2A);
    chk("wr_tx_be",   32'(r_be), 32'h5);
    chk("wr_tx_wd",   r_wd, 32'h1234_5678);

    do_cmd(2'd0, 1'b0, 6'h0F, 4'hF, 32'd0);
    expect_cmd("rd_csr", 6'b000001, 1, 4, 32'h0000_C5C5, 1'b0, 1'b0);
    chk("rd_csr_addr", 32'(r_addr), 32'h0F);

    do_cmd(2'd2, 1'b0, 6'h01, 4'hF, 32'd0);
    expect_cmd("rd_tx", 6'b010000, 1, 4, 32'hA1B2_C3D4, 1'b0, 1'b0);

    // Rejected commands respond the cycle after accept with no bus cycle
    do_cmd(2'd3, 1'b0, 6'h00, 4'hF, 32'd0);
    expect_cmd("err_t3", 6'b000000, -1, 1, 32'd0, 1'b0, 1'b1);
    do_cmd(2'd0, 1'b1, 6'h10, 4'hF, 32'hFFFF_FFFF);
    expect_cmd("err_csr_wr", 6'b000000, -1, 1, 32'd0, 1'b1, 1'b1);
    do_cmd(2'd0, 1'b0, 6'h30, 4'hF, 32'd0);
    expect_cmd("err_csr_rd", 6'b000000, -1, 1, 32'd0, 1'b0, 1'b1);

    do_cmd(2'd1, 1'b1, 6'h3F, 4'h3, 32'hCAFE_F00D);
    expect_cmd("wr_rx", 6'b001000, 1, 2, 32'd0, 1'b1, 1'b0);
    chk("wr_rx_be", 32'(r_be), 32'h3);

    // Response backpressure with a competing command presented
    wait_ready();
    cmd_valid = 1'b1; cmd_target = 2'd0; cmd_write = 1'b0; cmd_addr = 6'd5;
    cmd_byteenable = 4'hF; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("hold_seen", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1; cmd_target = 2'd2; cmd_write = 1'b1; cmd_addr = 6'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid",     32'(rsp_valid), 32'd1);
      chk("hold_data",      rsp_data, 32'h0000_C5C5);
      chk("hold_err",       32'(rsp_err), 32'd0);
      chk("hold_write",     32'(rsp_write), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_stb",       32'(stb), 32'd0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset asserted while waiting for read data
    wait_ready();
    cmd_valid = 1'b1; cmd_target = 2'd1; cmd_write = 1'b0; cmd_addr = 6'h3F; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_issue_strobe", 32'(rx_mm_read), 32'd1);
    @(negedge clk);
    chk("abort_pre_addr", 32'(rx_mm_address), 32'h3F);
    chk("abort_pre_ready", 32'(cmd_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_addr",      32'(rx_mm_address), 32'd0);
    chk("abort_stb",       32'(stb), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_wd",        rx_mm_writedata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    do_cmd(2'd1, 1'b0, 6'h15, 4'hF, 32'd0);
    expect_cmd("rd_after_abort", 6'b000100, 1, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // irq high for 3 cycles: single rise pulse after the two-flop synchroniser
    @(negedge clk);
    irq = 1'b1;
    rise_cnt = 0;
    rise_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (irq_rise) begin
        rise_cnt++;
        if (rise_cyc < 0) rise_cyc = c;
      end
      if (c == 2) chk("irq_sync_high", 32'(irq_sync), 32'd1);
      if (c == 3) irq = 1'b0;
    end
    chk("irq_rise_count", 32'(rise_cnt), 32'd1);
    chk("irq_rise_cycle", 32'(rise_cyc), 32'd2);
    chk("irq_sync_low",   32'(irq_sync), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
